// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch path: PC-mux select encodings,
// fetch FSM states and a saturating counter helper.
package fetch_pkg;

  localparam logic [1:0] SEL_SEQ   = 2'b01;  // pc + 4
  localparam logic [1:0] SEL_REDIR = 2'b00;  // branch/jump target from wb

  typedef enum logic [1:0] {
    BOOT,
    FETCH,
    STALL,
    ERR
  } fetch_state_t;

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

endpackage

// File: rtl/fetch_ctrl.sv
// Fetch controller: sequences PC updates, IF/ID capture and flushes around
// instruction-memory wait states, pipeline stalls and branch redirects.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int unsigned BOOT_CYCLES = 2,
  parameter int unsigned TIMEOUT     = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       imem_ack,
  input  logic       stall,
  input  logic       redirect,
  output logic       imem_req,
  output logic [1:0] pc_sel,
  output logic       pc_en,
  output logic       if_valid,
  output logic       flush,
  output logic       fetch_err
);

  localparam logic [3:0] BOOT_LAST = 4'(BOOT_CYCLES - 1);
  localparam logic [3:0] WAIT_LAST = 4'(TIMEOUT - 1);

  fetch_state_t state;
  logic [3:0]   boot_cnt;
  logic [3:0]   wait_cnt;
  logic         discard;  // an abandoned request is still in flight; drop its ack

  // NOTE: every output gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    imem_req = 1'b0;
    pc_sel   = SEL_SEQ;
    pc_en    = 1'b0;
    if_valid = 1'b0;
    flush    = 1'b0;
    case (state)
      FETCH: begin
        imem_req = 1'b1;
        if (redirect) begin
          pc_sel = SEL_REDIR;
          pc_en  = 1'b1;
          flush  = 1'b1;
        end else if (imem_ack && !discard) begin
          if_valid = 1'b1;
          pc_en    = !stall;
        end
      end
      STALL: begin
        if (redirect) begin
          pc_sel = SEL_REDIR;
          pc_en  = 1'b1;
          flush  = 1'b1;
        end else if (!stall) begin
          pc_en = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= BOOT;
      boot_cnt  <= 4'd0;
      wait_cnt  <= 4'd0;
      discard   <= 1'b0;
      fetch_err <= 1'b0;
    end else begin
      case (state)
        BOOT: begin
          boot_cnt <= sat_inc(boot_cnt);
          if (boot_cnt == BOOT_LAST) state <= FETCH;
        end
        FETCH: begin
          if (redirect) begin
            wait_cnt <= 4'd0;
            discard  <= !imem_ack;
          end else if (imem_ack) begin
            wait_cnt <= 4'd0;
            if (discard) discard <= 1'b0;
            else if (stall) state <= STALL;
          end else if (wait_cnt == WAIT_LAST) begin
            state     <= ERR;
            fetch_err <= 1'b1;
          end else begin
            wait_cnt <= sat_inc(wait_cnt);
          end
        end
        STALL: begin
          if (redirect || !stall) begin
            state   <= FETCH;
            discard <= 1'b0;
          end
        end
        ERR:     fetch_err <= 1'b1;  // sticky until rst
        default: state <= BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: each step drives one cycle of inputs, queues
// the expected output bundle and compares it mid-cycle.
module tb_fetch_ctrl;
  import fetch_pkg::*;

  logic       clk;
  logic       rst;
  logic       imem_ack;
  logic       stall;
  logic       redirect;
  logic       imem_req;
  logic [1:0] pc_sel;
  logic       pc_en;
  logic       if_valid;
  logic       flush;
  logic       fetch_err;

  fetch_ctrl #(.BOOT_CYCLES(2), .TIMEOUT(15)) dut (
    .clk      (clk),
    .rst      (rst),
    .imem_ack (imem_ack),
    .stall    (stall),
    .redirect (redirect),
    .imem_req (imem_req),
    .pc_sel   (pc_sel),
    .pc_en    (pc_en),
    .if_valid (if_valid),
    .flush    (flush),
    .fetch_err(fetch_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output bundle: {imem_req, pc_sel[1:0], pc_en, if_valid, flush, fetch_err}
  localparam logic [6:0] IDLE        = 7'b0_01_0_0_0_0;
  localparam logic [6:0] VALID       = 7'b1_01_1_1_0_0;
  localparam logic [6:0] WAITING     = 7'b1_01_0_0_0_0;
  localparam logic [6:0] REDIR       = 7'b1_00_1_0_1_0;
  localparam logic [6:0] HOLD_ACK    = 7'b1_01_0_1_0_0;
  localparam logic [6:0] RESUME      = 7'b0_01_1_0_0_0;
  localparam logic [6:0] STALL_REDIR = 7'b0_00_1_0_1_0;
  localparam logic [6:0] ERRV        = 7'b0_01_0_0_0_1;

  typedef struct {
    string      tag;
    logic [6:0] exp;
  } sb_entry_t;

  sb_entry_t sb_q[$];
  int checks   = 0;
  int failures = 0;

  task automatic step(input string tag, input logic r, input logic a,
                      input logic s, input logic d, input logic [6:0] e);
    sb_entry_t   ent;
    logic [6:0]  obs;
    rst      = r;
    imem_ack = a;
    stall    = s;
    redirect = d;
    sb_q.push_back('{tag, e});
    #4;
    ent = sb_q.pop_front();
    obs = {imem_req, pc_sel, pc_en, if_valid, flush, fetch_err};
    checks++;
    assert (obs === ent.exp)
    else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", ent.tag, obs, ent.exp);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; imem_ack = 1'b0; stall = 1'b0; redirect = 1'b0;
    @(posedge clk);
    #1;

    // Boot with ack tied high: first request in cycle 3
    step("boot_c1", 0, 1, 0, 0, IDLE);
    step("boot_c2", 0, 1, 0, 0, IDLE);
    for (int i = 0; i < 3; i++) step("run_ack", 0, 1, 0, 0, VALID);

    // Three wait states then an ack
    for (int i = 0; i < 3; i++) step("wait_state", 0, 0, 0, 0, WAITING);
    step("wait_done", 0, 1, 0, 0, VALID);

    // Redirect while waiting: the stale ack is dropped
    step("pre_redir", 0, 0, 0, 0, WAITING);
    step("redir_wait", 0, 0, 0, 1, REDIR);
    step("discard_ack", 0, 1, 0, 0, WAITING);
    step("post_discard", 0, 1, 0, 0, VALID);

    // Stall at an ack, hold, release
    step("stall_ack", 0, 1, 1, 0, HOLD_ACK);
    step("stall_hold1", 0, 1, 1, 0, IDLE);
    step("stall_hold2", 0, 1, 1, 0, IDLE);
    step("stall_release", 0, 1, 0, 0, RESUME);
    step("after_stall", 0, 1, 0, 0, VALID);

    // Redirect during stall
    step("stall_ack2", 0, 1, 1, 0, HOLD_ACK);
    step("stall_redir", 0, 0, 1, 1, STALL_REDIR);
    step("after_sredir", 0, 1, 0, 0, VALID);

    // Redirect overrides a simultaneous ack and stall
    step("redir_ack_stall", 0, 1, 1, 1, REDIR);
    step("after_redir_ack", 0, 1, 0, 0, VALID);

    // Redirect at wait_cnt == TIMEOUT-1 wins over the timeout
    for (int i = 0; i < 14; i++) step("long_wait", 0, 0, 0, 0, WAITING);
    step("redir_at_limit", 0, 0, 0, 1, REDIR);
    step("discard_ack2", 0, 1, 0, 0, WAITING);

    // Full timeout: 15 FETCH cycles without ack
    for (int i = 0; i < 15; i++) step("to_wait", 0, 0, 0, 0, WAITING);
    step("err_entry", 0, 0, 0, 0, ERRV);
    step("err_sticky", 0, 1, 0, 1, ERRV);
    step("err_sticky2", 0, 1, 1, 0, ERRV);

    // Single-cycle reset leaves ERR
    step("err_rst", 1, 1, 0, 0, ERRV);
    step("rst_boot1", 0, 1, 0, 0, IDLE);
    step("rst_boot2", 0, 1, 0, 0, IDLE);
    step("rst_fetch", 0, 1, 0, 0, VALID);

    // Reset mid-wait clears wait_cnt
    step("mid_wait1", 0, 0, 0, 0, WAITING);
    step("mid_wait2", 0, 0, 0, 0, WAITING);
    step("mid_wait_rst", 1, 0, 0, 0, WAITING);
    step("mw_boot1", 0, 0, 0, 0, IDLE);
    step("mw_boot2", 0, 0, 0, 0, IDLE);
    for (int i = 0; i < 14; i++) step("mw_wait", 0, 0, 0, 0, WAITING);
    step("mw_ack", 0, 1, 0, 0, VALID);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
